dev_bus_master: RTL and testbench

DEV_BUS_MASTER -- requirements
Module: dev_bus_master

---
 rtl/dev_bus_master.sv | 150 +++++++++++++++
 tb/tb_dev_bus_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_bus_master.sv
// Single-command bus master: issues one write, read or masked poll per command
// on a simple device bus and returns one response per command.
module dev_bus_master #(
  parameter int unsigned DBITS    = 32,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [DBITS-1:0] CMD_ADDR,
  input  logic [DBITS-1:0] CMD_DATA,
  input  logic [DBITS-1:0] CMD_MASK,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [DBITS-1:0] RSP_DATA,
  output logic             RSP_ERR,
  output logic [DBITS-1:0] ABUS,
  output logic [DBITS-1:0] DBUS_OUT,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic             WE
);

  localparam int unsigned PW       = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
  localparam int unsigned GW       = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam int unsigned GAP_LAST = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;

  typedef enum logic [2:0] {IDLE, WR, RD, POLL_RD, POLL_WAIT, RESP} stateT;

  stateT            state, nextState;
  logic [DBITS-1:0] addrReg, dataReg, maskReg;
  logic [DBITS-1:0] nextAddr, nextData, nextMask;
  logic [DBITS-1:0] nextRspData, nextAbus, nextDbusOut;
  logic [PW-1:0]    pollCnt, nextPollCnt, pollInc;
  logic [GW-1:0]    gapCnt, nextGapCnt;
  logic             nextRspErr, nextCmdReady, nextRspValid, nextWe;
  logic             pollMatch;

  assign pollInc   = pollCnt + PW'(1);
  assign pollMatch = ((DBUS_IN ^ dataReg) & maskReg) == '0;

  // Next state plus next values of every registered output
  always_comb begin
    nextState   = state;
    nextAddr    = addrReg;
    nextData    = dataReg;
    nextMask    = maskReg;
    nextPollCnt = pollCnt;
    nextGapCnt  = gapCnt;
    nextRspData = RSP_DATA;
    nextRspErr  = RSP_ERR;

    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          nextAddr    = CMD_ADDR;
          nextData    = CMD_DATA;
          nextMask    = CMD_MASK;
          nextPollCnt = '0;
          nextGapCnt  = '0;
          case (CMD_OP)
            2'b00:   nextState = WR;
            2'b01:   nextState = RD;
            2'b10:   nextState = POLL_RD;
            default: begin
              nextState   = RESP;
              nextRspData = '0;
              nextRspErr  = 1'b1;
            end
          endcase
        end
      end
      WR: begin
        nextState   = RESP;
        nextRspData = '0;
        nextRspErr  = 1'b0;
      end
      RD: begin
        nextState   = RESP;
        nextRspData = DBUS_IN;
        nextRspErr  = 1'b0;
      end
      POLL_RD: begin
        nextPollCnt = pollInc;
        nextRspData = DBUS_IN;
        nextGapCnt  = '0;
        if (pollMatch) begin
          nextState  = RESP;
          nextRspErr = 1'b0;
        end else if (pollInc == PW'(POLL_MAX)) begin
          nextState  = RESP;
          nextRspErr = 1'b1;
        end else if (POLL_GAP == 0) begin
          nextState = POLL_RD;
        end else begin
          nextState = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (gapCnt == GW'(GAP_LAST)) nextState = POLL_RD;
        else nextGapCnt = gapCnt + GW'(1);
      end
      RESP: begin
        if (RSP_READY) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    nextCmdReady = (nextState == IDLE);
    nextRspValid = (nextState == RESP);
    nextWe       = (nextState == WR);
    nextAbus     = ((nextState == WR) || (nextState == RD) || (nextState == POLL_RD)) ? nextAddr : '0;
    nextDbusOut  = (nextState == WR) ? nextData : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      addrReg   <= '0;
      dataReg   <= '0;
      maskReg   <= '0;
      pollCnt   <= '0;
      gapCnt    <= '0;
      CMD_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      ABUS      <= '0;
      DBUS_OUT  <= '0;
      WE        <= 1'b0;
    end else begin
      state     <= nextState;
      addrReg   <= nextAddr;
      dataReg   <= nextData;
      maskReg   <= nextMask;
      pollCnt   <= nextPollCnt;
      gapCnt    <= nextGapCnt;
      CMD_READY <= nextCmdReady;
      RSP_VALID <= nextRspValid;
      RSP_DATA  <= nextRspData;
      RSP_ERR   <= nextRspErr;
      ABUS      <= nextAbus;
      DBUS_OUT  <= nextDbusOut;
      WE        <= nextWe;
    end
  end

endmodule

// File: tb/tb_dev_bus_master.sv
// Scoreboard bench for dev_bus_master: expected responses are queued at command
// issue and compared when the response handshake happens.
module tb_dev_bus_master;

  localparam int unsigned DBITS = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             CMD_VALID, CMD_READY;
  logic [1:0]       CMD_OP;
  logic [DBITS-1:0] CMD_ADDR, CMD_DATA, CMD_MASK;
  logic             RSP_VALID, RSP_READY, RSP_ERR;
  logic [DBITS-1:0] RSP_DATA, ABUS, DBUS_OUT, DBUS_IN;
  logic             WE;

  dev_bus_master #(.DBITS(DBITS), .POLL_GAP(4), .POLL_MAX(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_MASK(CMD_MASK),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .ABUS(ABUS), .DBUS_OUT(DBUS_OUT), .DBUS_IN(DBUS_IN), .WE(WE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rspT;

  rspT         expQ[$];
  rspT         expCur;
  int          checks = 0;
  int          errors = 0;
  int          negCyc = 0, weCnt = 0, rdCnt = 0, busAct = 0;
  int          rdCyc[$];
  logic [31:0] lastWeAddr = '0, lastWeData = '0;
  logic        prevValid = 1'b0;
  logic [31:0] heldData = '0;
  logic        heldErr = 1'b0;
  logic        counterEn = 1'b0;
  int          div = 0;
  logic [31:0] devVal = '0;

  assign DBUS_IN = devVal;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] d, input logic e);
    rspT r;
    r.data = d;
    r.err  = e;
    expQ.push_back(r);
  endtask

  // Device counter, bus activity monitor and response scoreboard
  always @(negedge CLK) begin
    negCyc++;
    if (counterEn) begin
      if (div == 2) begin
        div = 0;
        devVal = devVal + 32'd1;
      end else begin
        div++;
      end
    end
    if (WE) begin
      weCnt++;
      lastWeAddr = ABUS;
      lastWeData = DBUS_OUT;
    end
    if (ABUS != '0 && !WE) begin
      rdCnt++;
      rdCyc.push_back(negCyc);
    end
    if (ABUS != '0 || DBUS_OUT != '0 || WE) busAct++;
    if (RSP_VALID) begin
      if (prevValid) begin
        checkVal("rsp_hold_data", RSP_DATA, heldData);
        checkVal("rsp_hold_err", 32'(RSP_ERR), 32'(heldErr));
      end else begin
        heldData = RSP_DATA;
        heldErr  = RSP_ERR;
      end
    end
    prevValid = RSP_VALID;
    if (RSP_VALID && RSP_READY) begin
      if (expQ.size() == 0) begin
        checkVal("sb_unexpected", 32'd1, 32'd0);
      end else begin
        expCur = expQ.pop_front();
        checkVal("sb_data", RSP_DATA, expCur.data);
        checkVal("sb_err", 32'(RSP_ERR), 32'(expCur.err));
      end
    end
  end

  task automatic sendCmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask);
    @(posedge CLK);
    #1;
    checkVal("cmd_ready_pre", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_ADDR  = addr;
    CMD_DATA  = data;
    CMD_MASK  = mask;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'b00;
    CMD_ADDR  = $urandom;
    CMD_DATA  = $urandom;
    CMD_MASK  = $urandom;
  endtask

  task automatic waitResp(input int expLat, input int hold);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge CLK);
      n++;
      seen = RSP_VALID;
    end
    if (!seen) begin
      checkVal("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (expLat > 0) checkVal("latency", 32'(n), 32'(expLat));
    repeat (hold) @(negedge CLK);
    @(posedge CLK);
    #1 RSP_READY = 1'b1;
    @(negedge CLK);
    checkVal("cmd_ready_hs", 32'(CMD_READY), 32'd0);
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    checkVal("idle_ready", 32'(CMD_READY), 32'd1);
    checkVal("idle_valid", 32'(RSP_VALID), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    checkVal({tag, "_valid"}, 32'(RSP_VALID), 32'd0);
    checkVal({tag, "_rdata"}, RSP_DATA, 32'd0);
    checkVal({tag, "_rerr"}, 32'(RSP_ERR), 32'd0);
    checkVal({tag, "_abus"}, ABUS, 32'd0);
    checkVal({tag, "_dbus"}, DBUS_OUT, 32'd0);
    checkVal({tag, "_we"}, 32'(WE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, b0;
    RESET = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00;
    CMD_ADDR = '0; CMD_DATA = '0; CMD_MASK = '0; RSP_READY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkResetOutputs("reset");
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Write
    w0 = weCnt;
    pushExp(32'h0, 1'b0);
    sendCmd(2'b00, 32'hF000_0020, 32'h0000_00FA, 32'h0);
    waitResp(2, 0);
    checkVal("wr_we_cycles", 32'(weCnt - w0), 32'd1);
    checkVal("wr_abus", lastWeAddr, 32'hF000_0020);
    checkVal("wr_dbus", lastWeData, 32'h0000_00FA);

    // Read with 5 stalled response cycles
    devVal = 32'h1234;
    pushExp(32'h1234, 1'b0);
    sendCmd(2'b01, 32'hF000_0024, 32'h0, 32'h0);
    waitResp(2, 5);

    // Illegal op
    b0 = busAct;
    pushExp(32'h0, 1'b1);
    sendCmd(2'b11, 32'hF000_0028, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResp(1, 0);
    checkVal("ill_bus", 32'(busAct - b0), 32'd0);

    // Poll with mask 0 matches on first read
    devVal = 32'h55;
    r0 = rdCnt;
    pushExp(32'h55, 1'b0);
    sendCmd(2'b10, 32'hF000_0024, 32'hAA, 32'h0);
    waitResp(2, 0);
    checkVal("mask0_reads", 32'(rdCnt - r0), 32'd1);

    // Poll against a device counter stepping every 3 cycles: reads see 0,2,3,5,7
    devVal = 32'h0;
    div = 0;
    r0 = rdCnt;
    rdCyc.delete();
    pushExp(32'h7, 1'b0);
    sendCmd(2'b10, 32'hF000_0024, 32'h7, 32'hFF);
    counterEn = 1'b1;
    waitResp(0, 0);
    counterEn = 1'b0;
    checkVal("poll_reads", 32'(rdCnt - r0), 32'd5);
    for (int i = 1; i < rdCyc.size(); i++)
      checkVal("poll_spacing", 32'(rdCyc[i] - rdCyc[i-1]), 32'd5);

    // Poll timeout after 8 reads
    devVal = 32'h0;
    r0 = rdCnt;
    pushExp(32'h0, 1'b1);
    sendCmd(2'b10, 32'hF000_0030, 32'h1, 32'h1);
    waitResp(0, 0);
    checkVal("tmo_reads", 32'(rdCnt - r0), 32'd8);

    // Reset during the third poll wait
    r0 = rdCnt;
    sendCmd(2'b10, 32'hF000_0024, 32'h1, 32'h1);
    repeat (12) @(posedge CLK);
    #1;
    checkVal("rst_poll_reads", 32'(rdCnt - r0), 32'd3);
    checkVal("rst_in_wait", ABUS, 32'd0);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkResetOutputs("midpoll");
    @(posedge CLK);
    #1 RESET = 1'b1;
    devVal = 32'hBEEF;
    pushExp(32'hBEEF, 1'b0);
    sendCmd(2'b01, 32'hF000_0024, 32'h0, 32'h0);
    waitResp(2, 0);

    // Write interrupted by reset issues WE only once
    w0 = weCnt;
    sendCmd(2'b00, 32'hF000_0040, 32'h77, 32'h0);
    RESET = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (4) @(negedge CLK);
    checkVal("wr_rst_we", 32'(weCnt - w0), 32'd1);
    checkVal("wr_rst_valid", 32'(RSP_VALID), 32'd0);

    checkVal("sb_left", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
